// File: rtl/life_seq_ctrl.sv
// life_seq_ctrl: sequences the Game of Life board registers through pattern load, single-step and free-run.
// Define LIFE_SEQ_AUTOHALT_EN to stop a run automatically once the board stops changing.
module life_seq_ctrl #(
    parameter int ROWS = 8,
    parameter int PERIOD_W = 16,
    parameter int GEN_W = 16,
    localparam int AW = ROWS > 1 ? $clog2(ROWS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [PERIOD_W-1:0] period,
    input  logic                load_valid,
    output logic                load_ready,
    output logic                row_we,
    output logic [AW-1:0]       row_addr,
    output logic                board_we,
    input  logic                board_changed,
    output logic [GEN_W-1:0]    gen_count,
    output logic [1:0]          state,
    output logic                halted
);
    localparam logic [1:0] S_IDLE = 2'd0, S_LOAD = 2'd1, S_RUN = 2'd2;
    localparam logic [1:0] OP_LOAD = 2'd0, OP_STEP = 2'd1, OP_RUN = 2'd2, OP_STOP = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [AW-1:0]       row_addr_q, row_addr_d;
    logic                board_we_q, board_we_d;
    logic [GEN_W-1:0]    gen_q, gen_d;
    logic [PERIOD_W-1:0] per_q, per_d, cnt_q, cnt_d, cnt_nxt, pe;
    logic                halted_q, halted_d;
    logic                cmd_ready_q, cmd_ready_d, load_ready_q, load_ready_d;
    logic                cmd_acc, beat, last_row, still;

    assign cmd_acc  = cmd_valid & cmd_ready_q;
    assign beat     = load_valid & load_ready_q;
    assign last_row = row_addr_q == AW'(ROWS - 1);
    assign pe       = (period == '0) ? PERIOD_W'(1) : period;
    // cnt_q counts 1..per_q; the update fires in the cycle the count reaches per_q
    assign cnt_nxt  = (cnt_q == per_q) ? PERIOD_W'(1) : cnt_q + PERIOD_W'(1);

`ifdef LIFE_SEQ_AUTOHALT_EN
    assign still = board_we_q & ~board_changed;
`else
    logic unused_board_changed;
    assign unused_board_changed = board_changed;
    assign still = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            row_addr_q   <= '0;
            board_we_q   <= 1'b0;
            gen_q        <= '0;
            per_q        <= '0;
            cnt_q        <= '0;
            halted_q     <= 1'b0;
            cmd_ready_q  <= 1'b1;
            load_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_addr_q   <= row_addr_d;
            board_we_q   <= board_we_d;
            gen_q        <= gen_d;
            per_q        <= per_d;
            cnt_q        <= cnt_d;
            halted_q     <= halted_d;
            cmd_ready_q  <= cmd_ready_d;
            load_ready_q <= load_ready_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        row_addr_d = row_addr_q;
        board_we_d = 1'b0;
        gen_d      = gen_q + GEN_W'(board_we_q);
        per_d      = per_q;
        cnt_d      = cnt_q;
        halted_d   = halted_q;
        case (state_q)
            S_IDLE: if (cmd_acc) begin
                case (cmd_op)
                    OP_LOAD: begin
                        state_d    = S_LOAD;
                        row_addr_d = '0;
                        gen_d      = '0;
                        halted_d   = 1'b0;
                    end
                    OP_STEP: board_we_d = 1'b1;
                    OP_RUN: begin
                        state_d    = S_RUN;
                        per_d      = pe;
                        cnt_d      = PERIOD_W'(1);
                        board_we_d = pe == PERIOD_W'(1);
                    end
                    default: ;
                endcase
            end
            S_LOAD: if (beat) begin
                row_addr_d = last_row ? '0 : row_addr_q + AW'(1);
                state_d    = last_row ? S_IDLE : S_LOAD;
            end
            S_RUN: if ((cmd_acc && cmd_op == OP_STOP) || still) begin
                state_d  = S_IDLE;
                cnt_d    = '0;
                halted_d = halted_q | still;
            end else begin
                cnt_d      = cnt_nxt;
                board_we_d = cnt_nxt == per_q;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready_d  = state_d != S_LOAD;
        load_ready_d = state_d == S_LOAD;
    end

    assign cmd_ready  = cmd_ready_q;
    assign load_ready = load_ready_q;
    assign row_we     = beat;
    assign row_addr   = row_addr_q;
    assign board_we   = board_we_q;
    assign gen_count  = gen_q;
    assign state      = state_q;
    assign halted     = halted_q;
endmodule

// File: tb/tb_life_seq_ctrl.sv
// tb_life_seq_ctrl: scoreboard bench for life_seq_ctrl; expected update cycles and row addresses are queued at stimulus time.
module tb_life_seq_ctrl;
    localparam int ROWS = 8, PERIOD_W = 16, GEN_W = 3;
    localparam logic [1:0] OP_LOAD = 2'd0, OP_STEP = 2'd1, OP_RUN = 2'd2, OP_STOP = 2'd3;

    logic                clk = 1'b0, reset = 1'b1, cmd_valid = 1'b0, load_valid = 1'b0, board_changed = 1'b1;
    logic [1:0]          cmd_op = '0;
    logic [PERIOD_W-1:0] period = '0;
    logic                cmd_ready, load_ready, row_we, board_we, halted;
    logic [2:0]          row_addr;
    logic [GEN_W-1:0]    gen_count;
    logic [1:0]          state;
    int n_tests = 0, n_fail = 0, cyc = 0, t = 0;
    int bw_q[$];
    int row_q[$];

    life_seq_ctrl #(.ROWS(ROWS), .PERIOD_W(PERIOD_W), .GEN_W(GEN_W)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .period(period), .load_valid(load_valid), .load_ready(load_ready), .row_we(row_we),
        .row_addr(row_addr), .board_we(board_we), .board_changed(board_changed),
        .gen_count(gen_count), .state(state), .halted(halted)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [PERIOD_W-1:0] p);
        cmd_valid = 1'b1;
        cmd_op = op;
        period = p;
        tick(1);
        cmd_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_state", 32'(state), 0);
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        chk("rst_load_ready", 32'(load_ready), 0);
        chk("rst_row_we", 32'(row_we), 0);
        chk("rst_row_addr", 32'(row_addr), 0);
        chk("rst_board_we", 32'(board_we), 0);
        chk("rst_gen", 32'(gen_count), 0);
        chk("rst_halted", 32'(halted), 0);
        tick(2);
        reset = 1'b0;
    endtask

    initial forever begin
        @(negedge clk);
        if (!reset) begin
            chk("we_excl", 32'(board_we & row_we), 0);
            if (board_we) begin
                if (bw_q.size() == 0) chk("bw_unexp", 32'(board_we), 0);
                else chk("bw_cycle", cyc, bw_q.pop_front());
            end
            if (row_we) begin
                if (row_q.size() == 0) chk("row_we_unexp", 32'(row_we), 0);
                else chk("row_addr", 32'(row_addr), row_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        tick(1);
        do_reset();
        // single step
        t = cyc;
        bw_q.push_back(t + 1);
        send(OP_STEP, 0);
        chk("step_gen_t1", 32'(gen_count), 0);
        chk("step_cmd_ready", 32'(cmd_ready), 1);
        tick(1);
        chk("step_gen_t2", 32'(gen_count), 1);
        chk("step_state", 32'(state), 0);
        // pattern load with a two-beat gap
        for (int i = 0; i < ROWS; i++) row_q.push_back(i);
        send(OP_LOAD, 0);
        chk("load_state", 32'(state), 1);
        chk("load_cmd_ready", 32'(cmd_ready), 0);
        chk("load_ready", 32'(load_ready), 1);
        chk("load_gen_clr", 32'(gen_count), 0);
        for (int i = 0; i < ROWS + 2; i++) begin
            load_valid = (i != 3 && i != 4);
            tick(1);
        end
        load_valid = 1'b0;
        chk("load_done_state", 32'(state), 0);
        chk("load_done_ready", 32'(load_ready), 0);
        chk("load_done_addr", 32'(row_addr), 0);
        chk("load_done_gen", 32'(gen_count), 0);
        chk("load_done_cmd_ready", 32'(cmd_ready), 1);
        chk("rows_left", 32'(row_q.size()), 0);
        // run period 4, stop ten cycles later; period change mid-run is ignored
        t = cyc;
        bw_q.push_back(t + 4);
        bw_q.push_back(t + 8);
        send(OP_RUN, 4);
        period = 1;
        chk("run_state", 32'(state), 2);
        chk("run_cmd_ready", 32'(cmd_ready), 1);
        while (cyc < t + 10) tick(1);
        send(OP_STOP, 0);
        chk("stop_state", 32'(state), 0);
        chk("stop_gen", 32'(gen_count), 2);
        tick(3);
        // bring the counter to 6 with four back-to-back steps
        t = cyc;
        for (int k = 0; k < 4; k++) bw_q.push_back(t + k + 1);
        for (int k = 0; k < 4; k++) send(OP_STEP, 0);
        tick(1);
        chk("steps_gen", 32'(gen_count), 6);
        // period 0 behaves as 1; counter wraps
        t = cyc;
        for (int k = 1; k <= 5; k++) bw_q.push_back(t + k);
        send(OP_RUN, 0);
        for (int j = 0; j < 4; j++) begin
            chk("wrap_gen", 32'(gen_count), 32'((6 + j) % 8));
            tick(1);
        end
        chk("wrap_gen_t5", 32'(gen_count), 2);
        send(OP_STOP, 0);
        chk("wrap_gen_end", 32'(gen_count), 3);
        chk("wrap_state", 32'(state), 0);
        // board stops changing at the third update
        t = cyc;
`ifdef LIFE_SEQ_AUTOHALT_EN
        for (int k = 1; k <= 3; k++) bw_q.push_back(t + k);
`else
        for (int k = 1; k <= 5; k++) bw_q.push_back(t + k);
`endif
        send(OP_RUN, 1);
        while (cyc < t + 5) begin
            board_changed = (cyc != t + 3);
            tick(1);
        end
        board_changed = 1'b1;
`ifdef LIFE_SEQ_AUTOHALT_EN
        chk("halt_state", 32'(state), 0);
        chk("halt_flag", 32'(halted), 1);
        chk("halt_gen", 32'(gen_count), 6);
        send(OP_LOAD, 0);
        chk("halt_clr_by_load", 32'(halted), 0);
        chk("halt_load_state", 32'(state), 1);
        do_reset();
`else
        chk("nohalt_state", 32'(state), 2);
        send(OP_STOP, 0);
        chk("nohalt_flag", 32'(halted), 0);
        chk("nohalt_gen", 32'(gen_count), 0);
        chk("nohalt_idle", 32'(state), 0);
`endif
        // asynchronous reset in the middle of a run
        t = cyc;
        bw_q.push_back(t + 3);
        send(OP_RUN, 3);
        while (cyc < t + 4) tick(1);
        chk("pre_rst_gen", 32'(gen_count), 1);
        chk("pre_rst_state", 32'(state), 2);
        do_reset();
        tick(8);
        chk("post_rst_state", 32'(state), 0);
        chk("bw_left", 32'(bw_q.size()), 0);
        chk("rows_left_end", 32'(row_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/life_seq_ctrl.md
Name: life_seq_ctrl

Overview:
- Controller that sequences the Game of Life board register array (the per-cell write-enabled registers).
- Generates the board-wide next-generation write enable, plus the per-row write enable/address used to load an initial pattern.
- Supports three modes: load pattern, single-step, and free-running at a programmable update period.
- Maintains the generation count. Sits between the host/command interface and the board registers plus next-state logic.

Parameters:
- ROWS, 8, number of board rows loaded one row per beat
- PERIOD_W, 16, width of the run-mode update period
- GEN_W, 16, width of the generation counter

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command strobe
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_op  in  2  0=LOAD, 1=STEP, 2=RUN, 3=STOP
- period  in  PERIOD_W  run-mode update period in cycles, sampled on RUN accept
- load_valid  in  1  row data beat valid (row data routed directly to the board)
- load_ready  out  1  controller accepts a row beat
- row_we  out  1  write enable for row row_addr; equals load_valid & load_ready
- row_addr  out  $clog2(ROWS)  row being loaded
- board_we  out  1  whole-board next-generation write enable
- board_changed  in  1  next-state logic reports next gen differs from current
- gen_count  out  GEN_W  generations applied since last LOAD
- state  out  2  0=IDLE, 1=LOAD, 2=RUN, 3=reserved
- halted  out  1  optional-feature status; 0 when feature compiled out

Behaviour:
- Reset values, applied asynchronously: state=IDLE, cmd_ready=1, load_ready=0, row_we=0, row_addr=0, board_we=0, gen_count=0, halted=0, period counter=0.
- All outputs are registered except row_we, which is combinational load_valid & load_ready.
- cmd_ready = (state==IDLE) | (state==RUN). In LOAD, commands are not accepted.
- IDLE, command accepted in cycle T:
  - LOAD: state=LOAD, row_addr=0, gen_count=0, halted=0 from T+1. load_ready=1 from T+1.
  - STEP: board_we=1 for exactly cycle T+1; gen_count+1 visible T+2. State stays IDLE.
  - RUN: Pe=max(period,1) latched. state=RUN from T+1. board_we high in cycles T+k*Pe for k>=1; with Pe=1, board_we is high every cycle from T+1.
  - STOP: no effect.
- LOAD:
  - Each handshake increments row_addr.
  - The handshake at row_addr==ROWS-1 returns to IDLE next cycle. row_addr wraps to 0, load_ready drops.
  - Gaps in load_valid are allowed; state holds.
- RUN:
  - Only STOP has an effect; LOAD/STEP/RUN are accepted and ignored.
  - STOP accepted in cycle S: state=IDLE and board_we=0 from S+1. An update already asserted in cycle S completes.
  - period changes during RUN are ignored until the next RUN.
- gen_count increments on every edge where board_we=1. It wraps from 2^GEN_W-1 to 0.
- board_we and row_we are never high in the same cycle.
- Reset mid-LOAD or mid-RUN returns to reset values immediately. Partially loaded rows are not cleared by this block.

Optional Feature:
- Macro: LIFE_SEQ_AUTOHALT_EN.
- Defined:
  - In RUN, if board_changed=0 during a cycle with board_we=1, the controller goes to IDLE next cycle and sets halted=1. That update still counts in gen_count.
  - halted is cleared by LOAD accept or reset.
  - STEP is unaffected, and halted stays 0 on STEP.
- Undefined: board_changed is ignored and halted is tied 0.

Test Plan:
- Reset during RUN with period=3 -> all outputs at reset values the same cycle; no further board_we.
- LOAD with ROWS=8 and 8 beats, load_valid low on beats 3-4 -> row_we pulses with row_addr 0..7 in order; state returns to IDLE after the 8th beat; gen_count=0.
- STEP accepted at T -> board_we high only at T+1; gen_count 0->1 at T+2; cmd_ready stays 1.
- RUN with period=4 at T, STOP at T+10 -> board_we at T+4 and T+8 only; gen_count=2; state IDLE at T+11.
- RUN with period=0 for 5 cycles then STOP, GEN_W=3, starting gen_count=6 -> board_we every cycle; gen_count wraps 7->0->1...
- LIFE_SEQ_AUTOHALT_EN defined, RUN period=1, board_changed=0 at 3rd update -> halted=1, state IDLE, gen_count=3; without the macro, RUN continues.
